seqdet_ctrl: RTL
================

// Module: seqdet_ctrl
// PURPOSE
//  Programmable serial pattern-detection controller. Holds the pattern configuration and
//  arms/disarms detection. It applies overlap or non-overlap rules, counts matches and raises
//  a sticky interrupt with an acknowledge handshake.
//  It sits between the serial bit source and the host/control logic. It generalises the
//  fixed 1010 detector to any pattern of 1..MAX_LEN bits.
// PARAMETERS
//  MAX_LEN  8  maximum pattern length in bits (>=2)
//  CNT_W    8  width of the match counter
//  LEN_W    4  width of cfg_len; must hold MAX_LEN
// PORTS
//  clk          in   1        clock; all logic samples on the rising edge
//  reset        in   1        synchronous, active-high reset
//  cfg_we       in   1        load cfg_pattern/cfg_len/cfg_overlap (accepted only in IDLE)
//  cfg_pattern  in   MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
//  cfg_len      in   LEN_W    pattern length; legal range 1..MAX_LEN
//  cfg_overlap  in   1        1 = overlapping matches allowed; 0 = non-overlapping
//  start        in   1        arm detection (IDLE -> RUN)
//  stop         in   1        disarm detection (RUN -> IDLE)
//  din_valid    in   1        din is a new serial bit this cycle
//  din          in   1        serial data bit
//  irq_ack      in   1        clears irq
//  armed        out  1        1 while in RUN
//  match        out  1        one-cycle registered (Moore) pulse per detected pattern
//  match_count  out  CNT_W    saturating count of matches since last start
//  irq          out  1        sticky; set on match, cleared by irq_ack
//  cfg_err      out  1        one-cycle pulse on a rejected cfg_we
// BEHAVIOUR
//  Reset values: armed=0, match=0, match_count=0, irq=0, cfg_err=0, state=IDLE, hist=0, fill=0.
//  Reset configuration: pattern=...0001010 (1010 in low bits), len=4, overlap=0.
//  Reset asserted mid-run aborts detection immediately. No match is reported for bits in flight.
//  State IDLE:
//   - cfg_we with 1<=cfg_len<=MAX_LEN loads all three cfg fields on that edge.
//   - cfg_we with any other cfg_len leaves the config unchanged and pulses cfg_err.
//   - start: go to RUN. Clear hist, fill and match_count. irq is untouched.
//  State RUN:
//   - cfg_we is ignored and pulses cfg_err.
//   - stop: go to IDLE. A din_valid bit on the same cycle is discarded.
//   - start and stop asserted together: stop wins. start alone while in RUN is ignored.
//   - On each accepted bit:
//       hist <= {hist[MAX_LEN-2:0], din}
//       fill <= min(fill+1, len)
//   - A hit occurs when the new fill equals len AND the low len bits of the new hist equal
//     the low len bits of the pattern.
//   - After a hit:
//       non-overlap: fill <= 0, so the next match needs len fresh bits
//       overlap: fill stays at len
//   - Cycles without din_valid do not advance any state.
//  Latency: match is high for exactly the cycle after the edge that accepted the final bit.
//   Back-to-back overlapping hits give back-to-back match pulses.
//  match_count increments with each match and saturates at all ones (no wrap).
//  irq is set by a hit and cleared by irq_ack. If a hit and irq_ack occur on the same cycle,
//   irq stays 1.
//  With len=1, every bit equal to pattern[0] is a hit in either mode.
// TESTING
//  1. Reset, start, stream 1,0,1,0,1,0,1,0 (overlap=0) -> match pulses after bits 4 and 8;
//     match_count=2.
//  2. cfg len=4, pat=1010, overlap=1, same stream -> matches after bits 4, 6 and 8;
//     match_count=3.
//  3. cfg_we with cfg_len=0, then with cfg_len=9 (MAX_LEN=8) -> cfg_err pulses twice and the
//     config stays 1010/4.
//  4. In RUN: cfg_we -> cfg_err=1 and config unchanged. stop with din_valid on the same cycle
//     -> armed=0 next cycle and the bit has no effect.
//  5. Hit with irq_ack on the same cycle -> irq remains 1. irq_ack on a later idle cycle
//     -> irq=0.
//  6. CNT_W=2, overlap=1, pat=1/len=1, feed six 1s -> match_count saturates at 3 while match
//     still pulses six times.

Source files
------------

// File: rtl/seqdet_ctrl.sv
// -----------------------------------------------------------------------------
// seqdet_ctrl
//
// Programmable serial pattern-detection controller. A host loads a pattern of
// 1..MAX_LEN bits, arms the detector, and receives a registered match pulse, a
// saturating match counter and a sticky interrupt for every detected pattern.
// Overlapping or non-overlapping matching is selected per configuration.
//
// Ports
//   clk          in   1        clock, rising edge
//   reset        in   1        synchronous, active-high reset
//   cfg_we       in   1        configuration write (honoured only while idle)
//   cfg_pattern  in   MAX_LEN  pattern; bit [len-1] is received first, bit [0] last
//   cfg_len      in   LEN_W    pattern length, legal range 1..MAX_LEN
//   cfg_overlap  in   1        1 = overlapping matches, 0 = non-overlapping
//   start        in   1        arm detection
//   stop         in   1        disarm detection (wins over start)
//   din_valid    in   1        din carries a new serial bit this cycle
//   din          in   1        serial data bit
//   irq_ack      in   1        clears irq
//   armed        out  1        high while detection is armed
//   match        out  1        one-cycle pulse, the cycle after the final bit
//   match_count  out  CNT_W    saturating match count since the last start
//   irq          out  1        sticky match interrupt
//   cfg_err      out  1        one-cycle pulse for a rejected cfg_we
// -----------------------------------------------------------------------------
module seqdet_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               start,
  input  logic               stop,
  input  logic               din_valid,
  input  logic               din,
  input  logic               irq_ack,
  output logic               armed,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               irq,
  output logic               cfg_err
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // ---------------------------------------------------------------------------
  if (MAX_LEN < 2) begin : g_bad_max_len
    $error("seqdet_ctrl: MAX_LEN must be at least 2");
  end
  if ((64'd1 << LEN_W) <= 64'(MAX_LEN)) begin : g_bad_len_w
    $error("seqdet_ctrl: LEN_W too narrow to hold MAX_LEN");
  end

  // Power-on configuration: the classic 1010 detector, non-overlapping.
  localparam logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(4'b1010);
  localparam logic [LEN_W-1:0]   RST_LEN     = LEN_W'(4);
  localparam logic [LEN_W-1:0]   MAX_LEN_L   = LEN_W'(MAX_LEN);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;

  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;

  // Only the MAX_LEN-1 previous bits are stored; the newest bit of every
  // comparison window comes straight from din.
  logic [MAX_LEN-2:0] hist_q;
  logic [LEN_W-1:0]   fill_q;

  logic               match_q;
  logic [CNT_W-1:0]   match_count_q;
  logic               irq_q;
  logic               cfg_err_q;

  // ---------------------------------------------------------------------------
  // Datapath decode
  // ---------------------------------------------------------------------------
  logic               len_ok;
  logic               cfg_reject;
  logic               bit_accept;
  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_inc;
  logic               hit;

  assign len_ok     = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
  // Any write while armed is rejected; while idle only an illegal length is.
  assign cfg_reject = cfg_we && ((state_q == S_RUN) || !len_ok);
  // stop discards a bit arriving on the same cycle.
  assign bit_accept = (state_q == S_RUN) && din_valid && !stop;
  assign hist_shift = {hist_q, din};

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end

    // fill counts valid history bits and never exceeds the pattern length.
    fill_inc = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);

    hit = bit_accept
          && (fill_inc == len_q)
          && (((hist_shift ^ pat_q) & len_mask) == '0);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (stop)  state_d = S_IDLE;   // start while armed is ignored
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Configuration registers (writable only while idle)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q <= RST_PATTERN;
      len_q <= RST_LEN;
      ovl_q <= 1'b0;
    end else if (cfg_we && !cfg_reject) begin
      pat_q <= cfg_pattern;
      len_q <= cfg_len;
      ovl_q <= cfg_overlap;
    end
  end

  // ---------------------------------------------------------------------------
  // Detection history and fill level
  // ---------------------------------------------------------------------------
  // NOTE: the history shift register is reset along with the control state;
  // fill already masks stale bits, but a defined hist keeps restarts and
  // reset-mid-run behaviour fully deterministic.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (bit_accept) begin
      hist_q <= hist_shift[MAX_LEN-2:0];
      // Non-overlap: a hit consumes its bits, so the next match needs len
      // fresh ones. Overlap: the window stays full and slides on.
      fill_q <= (hit && !ovl_q) ? '0 : fill_inc;
    end
  end

  // ---------------------------------------------------------------------------
  // Match pulse, counter, interrupt and config-error pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      match_q       <= 1'b0;
      match_count_q <= '0;
      irq_q         <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      match_q   <= hit;
      cfg_err_q <= cfg_reject;

      // start and hit are mutually exclusive: hits only occur while armed.
      if ((state_q == S_IDLE) && start) begin
        match_count_q <= '0;
      end else if (hit && (match_count_q != '1)) begin
        match_count_q <= match_count_q + CNT_W'(1);
      end

      // A hit on the acknowledge cycle keeps the interrupt pending.
      irq_q <= hit | (irq_q & ~irq_ack);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    armed       = (state_q == S_RUN);
    match       = match_q;
    match_count = match_count_q;
    irq         = irq_q;
    cfg_err     = cfg_err_q;
  end

endmodule
